// File: rtl/uart_pkg.sv
// Shared types and constants for the word-wide UART transmitter.
// Define PARITY_EN to add an even-parity bit to every byte frame.
package uart_pkg;

  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned BYTES_PER_WORD  = 4;
  localparam int unsigned CLK_DIV_DEFAULT = 5;

`ifdef PARITY_EN
  localparam int unsigned FRAME_BITS = DATA_BITS + 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_e;
`else
  localparam int unsigned FRAME_BITS = DATA_BITS + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } txState_e;
`endif

  localparam int unsigned WORD_BITS = FRAME_BITS * BYTES_PER_WORD;

  // Even parity: the extra bit makes the count of ones in the frame payload even.
  function automatic logic evenParity(input logic [DATA_BITS-1:0] payload);
    return ^payload;
  endfunction

endpackage

// File: rtl/clock_divider.sv
// Bit-rate generator: a square wave toggling every CLK_DIV clocks, plus a
// one-cycle tick coinciding with each rising edge of that wave.
module clock_divider
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic rst,
  input  logic enable,
  output logic bit_clock,
  output logic bit_tick
);

  localparam logic [15:0] LAST_COUNT = 16'(CLK_DIV - 1);

  logic [15:0] count_q, count_d;
  logic        bitClock_q, bitClock_d;
  logic        wrap;

  // When stopped the divider parks at zero so the first tick after a
  // request always lands exactly CLK_DIV clocks later.
  always_comb begin
    wrap       = enable && (count_q == LAST_COUNT);
    count_d    = '0;
    bitClock_d = 1'b0;
    if (enable) begin
      count_d    = wrap ? 16'd0 : count_q + 16'd1;
      bitClock_d = wrap ? ~bitClock_q : bitClock_q;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      bitClock_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      bitClock_q <= bitClock_d;
    end
  end

  assign bit_clock = bitClock_q;
  assign bit_tick  = wrap && !bitClock_q;

endmodule

// File: rtl/shift_register_tx.sv
// Sends a 32-bit word as four LSB-first UART byte frames, low byte first.
// Define PARITY_EN to add an even-parity bit after each byte's data bits.
module shift_register_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] data_in,
  output logic        tx_serial,
  output logic        tx_complete,
  output logic        bit_clock
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  txState_e       state_q, state_d;
  logic [31:0]    word_q, word_d;
  logic [2:0]     bitIdx_q, bitIdx_d;
  logic [1:0]     byteIdx_q, byteIdx_d;
  logic           txSerial_q, txSerial_d;
  logic           txComplete_q, txComplete_d;
  logic [DATA_BITS-1:0] curByte;
  logic           divRun;
  logic           bitTick;

  // Keep the divider running through a whole word even if enable drops.
  assign divRun = enable || (state_q != IDLE);

  clock_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_divider (
    .clock     (clock),
    .rst       (rst),
    .enable    (divRun),
    .bit_clock (bit_clock),
    .bit_tick  (bitTick)
  );

  assign curByte = word_q[{byteIdx_q, 3'b000} +: DATA_BITS];

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    bitIdx_d     = bitIdx_q;
    byteIdx_d    = byteIdx_q;
    txSerial_d   = txSerial_q;
    txComplete_d = txComplete_q;

    if (bitTick) begin
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            word_d       = data_in;
            bitIdx_d     = '0;
            byteIdx_d    = '0;
            txSerial_d   = 1'b0;
            txComplete_d = 1'b0;
            state_d      = START;
          end
        end

        // Also ends the one-bit-period completion pulse of a back-to-back word.
        START: begin
          txComplete_d = 1'b0;
          bitIdx_d     = '0;
          txSerial_d   = curByte[0];
          state_d      = DATA;
        end

        DATA: begin
          if (bitIdx_q == LAST_BIT) begin
            bitIdx_d = '0;
`ifdef PARITY_EN
            txSerial_d = evenParity(curByte);
            state_d    = PARITY;
`else
            txSerial_d = 1'b1;
            state_d    = STOP;
`endif
          end else begin
            bitIdx_d   = bitIdx_q + 3'd1;
            txSerial_d = curByte[bitIdx_q + 3'd1];
          end
        end

`ifdef PARITY_EN
        PARITY: begin
          txSerial_d = 1'b1;
          state_d    = STOP;
        end
`endif

        STOP: begin
          if (byteIdx_q == LAST_BYTE) begin
            txComplete_d = 1'b1;
            byteIdx_d    = '0;
            if (enable) begin
              word_d     = data_in;
              txSerial_d = 1'b0;
              state_d    = START;
            end else begin
              txSerial_d = 1'b1;
              state_d    = IDLE;
            end
          end else begin
            byteIdx_d  = byteIdx_q + 2'd1;
            txSerial_d = 1'b0;
            state_d    = START;
          end
        end

        default: begin
          txSerial_d   = 1'b1;
          txComplete_d = 1'b1;
          state_d      = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      bitIdx_q     <= '0;
      byteIdx_q    <= '0;
      txSerial_q   <= 1'b1;
      txComplete_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      bitIdx_q     <= bitIdx_d;
      byteIdx_q    <= byteIdx_d;
      txSerial_q   <= txSerial_d;
      txComplete_q <= txComplete_d;
    end
  end

  assign tx_serial   = txSerial_q;
  assign tx_complete = txComplete_q;

endmodule

// File: tb/tb_shift_register_tx.sv
// Self-checking bench for shift_register_tx; build with PARITY_EN defined to
// exercise the parity variant against the same line model.
module tb_shift_register_tx;

  localparam int DIV = 5;
  localparam int BIT = 2 * DIV;
`ifdef PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int WORD_LEN = 4 * FRAME;

  logic        clock = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] data_in;
  logic        tx_serial, tx_complete, bit_clock;

  logic        enable1;
  logic [31:0] data1;
  logic        txSerial1, txComplete1, bitClock1;

  int errorCount = 0;
  int checkCount = 0;
  bit expQ[$];

  always #5 clock = ~clock;

  shift_register_tx #(.CLK_DIV(DIV)) dut (
    .clock       (clock),
    .rst         (rst),
    .enable      (enable),
    .data_in     (data_in),
    .tx_serial   (tx_serial),
    .tx_complete (tx_complete),
    .bit_clock   (bit_clock)
  );

  shift_register_tx #(.CLK_DIV(1)) dut1 (
    .clock       (clock),
    .rst         (rst),
    .enable      (enable1),
    .data_in     (data1),
    .tx_serial   (txSerial1),
    .tx_complete (txComplete1),
    .bit_clock   (bitClock1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Line model: each byte becomes start(0), 8 data bits LSB first, optional
  // even parity, stop(1); bytes go out lowest first.
  task automatic appendWord(input logic [31:0] word);
    logic [7:0] byteVal;
    for (int b = 0; b < 4; b++) begin
      byteVal = word[8*b +: 8];
      expQ.push_back(1'b0);
      for (int k = 0; k < 8; k++) expQ.push_back(byteVal[k]);
`ifdef PARITY_EN
      expQ.push_back(($countones(byteVal) % 2) == 1);
`endif
      expQ.push_back(1'b1);
    end
  endtask

  task automatic stepCycle(inout int c, input int holdCycles, input int switchAt, input logic [31:0] w1);
    @(negedge clock);
    c++;
    if (c == holdCycles) enable = 1'b0;
    if (c == switchAt) data_in = w1;
  endtask

  // Raises enable from idle, then watches nBits bit periods of the line,
  // sampling mid-bit and counting cycles with tx_complete high.
  task automatic applyStimulus(input string name, input logic [31:0] w0, input logic [31:0] w1,
                               input int holdCycles, input int switchAt, input int nBits,
                               input int expHigh);
    int  c = 0;
    int  highCycles = 0;
    bit  found = 1'b0;
    data_in = w0;
    enable  = 1'b1;
    for (int t = 0; t < 100 && !found; t++) begin
      stepCycle(c, holdCycles, switchAt, w1);
      if (tx_serial == 1'b0) found = 1'b1;
    end
    if (!found) begin
      checkOutput({name, "_startTimeout"}, 32'd0, 32'd1);
      enable = 1'b0;
      return;
    end
    checkOutput({name, "_latency"}, c, DIV);
    for (int i = 0; i < nBits * BIT; i++) begin
      if (i != 0) stepCycle(c, holdCycles, switchAt, w1);
      if (tx_complete) highCycles++;
      if (i % BIT == BIT / 2)
        checkOutput($sformatf("%s_bit%0d", name, i / BIT), tx_serial, expQ[i / BIT]);
    end
    stepCycle(c, holdCycles, switchAt, w1);
    checkOutput({name, "_doneFlag"}, tx_complete, 1);
    checkOutput({name, "_completeHighCycles"}, highCycles, expHigh);
    enable = 1'b0;
    expQ.delete();
    repeat (20) @(negedge clock);
  endtask

  initial begin
    logic [31:0] rw;
    rst = 1'b1; enable = 1'b0; data_in = '0; enable1 = 1'b0; data1 = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_txSerial", tx_serial, 1);
    checkOutput("reset_txComplete", tx_complete, 1);
    checkOutput("reset_bitClock", bit_clock, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge clock);
      checkOutput($sformatf("idle_bitClock%0d", i), bit_clock, 0);
      checkOutput($sformatf("idle_txSerial%0d", i), tx_serial, 1);
    end

    appendWord(32'h12345678);
    applyStimulus("single", 32'h12345678, 32'h12345678, BIT, -1, WORD_LEN, 0);

    appendWord(32'hA5A5A5A5);
    applyStimulus("stable", 32'hA5A5A5A5, 32'hDEADBEEF, BIT, DIV + 15 * BIT, WORD_LEN, 0);

    appendWord(32'hFFFFFFFF);
    appendWord(32'h00000000);
    applyStimulus("b2b", 32'hFFFFFFFF, 32'h00000000, DIV + WORD_LEN * BIT + BIT, DIV + 2 * BIT,
                  2 * WORD_LEN, BIT);

`ifdef PARITY_EN
    appendWord(32'h00000107);
    applyStimulus("parity", 32'h00000107, 32'h00000107, BIT, -1, WORD_LEN, 0);
`endif

    for (int r = 0; r < 3; r++) begin
      rw = $urandom;
      appendWord(rw);
      applyStimulus($sformatf("rand%0d", r), rw, $urandom, 1 + $urandom_range(BIT - 1, 0) + DIV - 1,
                    DIV + $urandom_range(30 * BIT, BIT), WORD_LEN, 0);
    end

    // Divide-by-one instance: wave toggles every clock, bits last two clocks.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput($sformatf("div1_idleBitClock%0d", i), bitClock1, 0);
    end
    data1 = 32'h00000001;
    enable1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput($sformatf("div1_bitClock%0d", i), bitClock1, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("div1_txSerial%0d", i), txSerial1, (i < 2) ? 0 : 1);
    end
    enable1 = 1'b0;

    // Reset in the middle of a start bit while the bit clock is high.
    data_in = 32'h12345678;
    enable  = 1'b1;
    repeat (DIV + 2) @(negedge clock);
    checkOutput("midFrame_txSerialBefore", tx_serial, 0);
    checkOutput("midFrame_bitClockBefore", bit_clock, 1);
    checkOutput("midFrame_txCompleteBefore", tx_complete, 0);
    rst = 1'b1;
    #1;
    checkOutput("midReset_txSerial", tx_serial, 1);
    checkOutput("midReset_txComplete", tx_complete, 1);
    checkOutput("midReset_bitClock", bit_clock, 0);
    enable = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (10) @(negedge clock);
      checkOutput($sformatf("postReset_txSerial%0d", i), tx_serial, 1);
      checkOutput($sformatf("postReset_bitClock%0d", i), bit_clock, 0);
    end

    appendWord(32'hC3C3_0F0F);
    applyStimulus("afterReset", 32'hC3C3_0F0F, 32'hC3C3_0F0F, BIT, -1, WORD_LEN, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
